// File: rtl/incr_adc_sequencer.sv
`timescale 1ns/1ps
// Conversion sequencer for the incremental sigma-delta path: resets modulator and
// filter per conversion, waits for new_data, and holds the result for the host.
//
// state   | meaning
// IDLE    | filter and modulator held in reset, waiting for start
// RESET   | per-conversion reset pulse, RST_CYCLES clocks long
// CONVERT | filter released, waiting for new_data or timeout
module incr_adc_sequencer #(
    parameter int WIDTH      = 12,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             clear_err,
    input  logic [WIDTH-1:0] filt_data,
    input  logic             filt_new_data,
    output logic             filt_rst_n,
    output logic             mod_rst,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int CW  = $clog2(TIMEOUT);
    localparam int RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESET   = 2'd1,
        CONVERT = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [RCW-1:0] rst_cnt;
    logic [CW-1:0]  cyc_cnt;
    logic           conv_done;
    logic           tmo;
    logic           ovr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            filt_rst_n <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            filt_rst_n <= (state_nx == CONVERT);
            busy       <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx  = state;
        conv_done = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RESET;
            end
            RESET: begin
                if (rst_cnt == '0) state_nx = CONVERT;
            end
            CONVERT: begin
                if (filt_new_data) conv_done = 1'b1;
                else if (cyc_cnt == CW'(TIMEOUT - 1)) tmo = 1'b1;
                // a timeout ends the conversion exactly like new_data does
                if (conv_done || tmo) state_nx = cont ? RESET : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            if (state_nx == RESET && state != RESET) rst_cnt <= RCW'(RST_CYCLES - 1);
            else if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;

            if (state != CONVERT) cyc_cnt <= '0;
            else cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    // overwrite only counts as overrun if the consumer is not taking the old value now
    assign ovr_set = conv_done && result_valid && !result_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (conv_done) begin
                result       <= filt_data;
                result_valid <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            overrun     <= ovr_set | (overrun & ~clear_err);
            timeout_err <= tmo | (timeout_err & ~clear_err);
        end
    end

    assign mod_rst = ~filt_rst_n;

endmodule

// File: tb/tb_incr_adc_sequencer.sv
`timescale 1ns/1ps
// Directed-plus-random bench for incr_adc_sequencer with a behavioural filter model
// and an expected-result model of the holding register and sticky flags.
module tb_incr_adc_sequencer;

    localparam int W      = 12;
    localparam int RC     = 2;
    localparam int TO     = 1024;
    localparam int CONV   = 515;
    localparam int PERIOD = RC + CONV;
    localparam int NRAND  = 5;

    logic         clk = 1'b0;
    logic         rst, start, cont, clear_err, result_ready;
    logic [W-1:0] filt_data;
    logic         filt_new_data;
    logic         filt_rst_n, mod_rst, busy, result_valid, overrun, timeout_err;
    logic [W-1:0] result;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [W-1:0] fm_q[$];
    bit           fm_enable = 1'b1;
    bit           fm_stray  = 1'b0;
    int           fm_hi     = 0;

    incr_adc_sequencer #(.WIDTH(W), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont         (cont),
        .clear_err    (clear_err),
        .filt_data    (filt_data),
        .filt_new_data(filt_new_data),
        .filt_rst_n   (filt_rst_n),
        .mod_rst      (mod_rst),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // filter model: new_data in the 515th cycle after its reset is released
    initial begin
        filt_new_data = 1'b0;
        filt_data     = '0;
        forever begin
            @(negedge clk);
            fm_hi = filt_rst_n ? fm_hi + 1 : 0;
            if (fm_enable && fm_hi == CONV) begin
                filt_new_data = 1'b1;
                filt_data     = (fm_q.size() > 0) ? fm_q.pop_front() : W'($urandom);
            end else begin
                filt_new_data = fm_stray;
                filt_data     = W'($urandom);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(output int c0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_capture(input int budget, input int ready_at, input bit rdy_cap);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            tick();
            n++;
            found = filt_new_data && filt_rst_n;
            result_ready = (n == ready_at) || (rdy_cap && found);
        end
        check("cap_seen", 32'(found), 32'd1);
        tick();
        result_ready = 1'b0;
    endtask

    task automatic measure_low(output int lo);
        lo = 0;
        while (!filt_rst_n && lo < 5000) begin
            lo++;
            tick();
        end
    endtask

    task automatic measure_high(input int ce_at, output int hi);
        hi = 0;
        while (filt_rst_n && hi < 5000) begin
            hi++;
            start     = (hi == 100);
            clear_err = (hi == ce_at);
            if (ce_at > 0 && hi == ce_at - 1) check("tmo_early", 32'(timeout_err), 32'd0);
            tick();
        end
        start     = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic read_pulse();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("read_clears_valid", 32'(result_valid), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_filt_rst_n"}, 32'(filt_rst_n), 32'd0);
        check({tag, "_mod_rst"}, 32'(mod_rst), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int           c0, lo, hi;
        logic [W-1:0] vals[4];
        logic [W-1:0] rv[NRAND];
        bit           rd[NRAND];
        int           dl[NRAND];
        int           ra;
        bit           exp_valid, exp_ovr;
        logic [W-1:0] va, vb;

        rst = 1'b1; start = 1'b0; cont = 1'b0; clear_err = 1'b0; result_ready = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (3) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_filt_rst_n", 32'(filt_rst_n), 32'd0);

        // single shot, with a stray start during CONVERT
        fm_q.push_back(12'h5A3);
        do_start(c0);
        check("ss_busy_rise", 32'(busy), 32'd1);
        measure_low(lo);
        check("ss_low_len", 32'(lo), 32'(RC));
        check("ss_mod_rst_conv", 32'(mod_rst), 32'd0);
        measure_high(0, hi);
        check("ss_high_len", 32'(hi), 32'(CONV));
        check("ss_result", 32'(result), 32'h5A3);
        check("ss_valid", 32'(result_valid), 32'd1);
        check("ss_busy_fall", 32'(busy), 32'd0);
        repeat (4) tick();
        check("ss_stays_idle", 32'(busy), 32'd0);
        read_pulse();
        check("ss_result_held", 32'(result), 32'h5A3);

        // continuous with handshake 10 cycles after each valid
        vals[0] = 12'h001; vals[1] = 12'h7FF; vals[2] = 12'hFFF; vals[3] = 12'h800;
        foreach (vals[k]) fm_q.push_back(vals[k]);
        cont = 1'b1;
        do_start(c0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) cont = 1'b0;
            wait_capture(700, (k > 0) ? 10 : 0, 1'b0);
            check($sformatf("ct_result%0d", k), 32'(result), 32'(vals[k]));
            check($sformatf("ct_valid%0d", k), 32'(result_valid), 32'd1);
            check($sformatf("ct_period%0d", k), 32'(cyc - c0), 32'(PERIOD));
            c0 = cyc;
        end
        check("ct_busy_end", 32'(busy), 32'd0);
        check("ct_overrun", 32'(overrun), 32'd0);
        repeat (10) tick();
        read_pulse();

        // randomized reads against the holding-register model
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        for (int k = 0; k < NRAND; k++) begin
            rv[k] = W'($urandom);
            rd[k] = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            dl[k] = $urandom_range(1, 400);
            fm_q.push_back(rv[k]);
        end
        cont = 1'b1;
        do_start(c0);
        for (int k = 0; k < NRAND; k++) begin
            if (k == NRAND - 1) cont = 1'b0;
            ra = (k > 0 && rd[k-1]) ? dl[k-1] : 0;
            if (ra > 0) exp_valid = 1'b0;
            wait_capture(700, ra, 1'b0);
            exp_ovr   = exp_ovr | exp_valid;
            exp_valid = 1'b1;
            check($sformatf("rn_result%0d", k), 32'(result), 32'(rv[k]));
            check($sformatf("rn_valid%0d", k), 32'(result_valid), 32'(exp_valid));
            check($sformatf("rn_overrun%0d", k), 32'(overrun), 32'(exp_ovr));
        end
        check("rn_busy_end", 32'(busy), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("rn_clear_overrun", 32'(overrun), 32'd0);
        check("rn_valid_kept", 32'(result_valid), 32'd1);
        read_pulse();

        // ready on exactly the capture edge
        va = W'($urandom);
        vb = va ^ 12'h555;
        fm_q.push_back(va);
        fm_q.push_back(vb);
        cont = 1'b1;
        do_start(c0);
        wait_capture(700, 0, 1'b0);
        check("col_first", 32'(result), 32'(va));
        cont = 1'b0;
        wait_capture(700, 0, 1'b1);
        check("col_result", 32'(result), 32'(vb));
        check("col_valid", 32'(result_valid), 32'd1);
        check("col_overrun", 32'(overrun), 32'd0);
        check("col_busy", 32'(busy), 32'd0);
        read_pulse();

        // timeout, with clear_err on the setting edge
        fm_enable = 1'b0;
        do_start(c0);
        measure_low(lo);
        measure_high(TO, hi);
        check("to_conv_len", 32'(hi), 32'(TO));
        check("to_flag_set_wins", 32'(timeout_err), 32'd1);
        check("to_valid", 32'(result_valid), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_clear", 32'(timeout_err), 32'd0);

        // new_data while idle must be ignored
        fm_enable = 1'b1;
        fm_stray  = 1'b1;
        repeat (2) tick();
        fm_stray = 1'b0;
        repeat (2) tick();
        check("stray_valid", 32'(result_valid), 32'd0);
        check("stray_result", 32'(result), 32'(vb));
        check("stray_busy", 32'(busy), 32'd0);

        // reset 200 cycles into CONVERT, then a clean conversion
        cont = 1'b1;
        fm_q.push_back(W'($urandom));
        do_start(c0);
        measure_low(lo);
        repeat (200) tick();
        check("mid_in_conv", 32'(filt_rst_n), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("mid");
        repeat (2) tick();
        rst = 1'b0;
        fm_q.delete();
        fm_q.push_back(12'h3C6);
        cont = 1'b0;
        do_start(c0);
        measure_low(lo);
        check("post_low_len", 32'(lo), 32'(RC));
        measure_high(0, hi);
        check("post_high_len", 32'(hi), 32'(CONV));
        check("post_result", 32'(result), 32'h3C6);
        check("post_valid", 32'(result_valid), 32'd1);
        check("post_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
